// File: rtl/cv32e40x_aes_protected_ctrl.sv
// Sequencer for the masked (DOM) AES32 functional unit: accepts one saes32 at a time,
// feeds one fresh RNG word per sbox advance and hands back the result with valid/ready.
module cv32e40x_aes_protected_ctrl #(
  parameter int SBOX_LATENCY = 3,
  parameter int RND_WIDTH    = 36
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3:0]           op_i,
  input  logic [1:0]           bs_i,
  input  logic                 kill_i,
  input  logic                 rnd_valid_i,
  input  logic [RND_WIDTH-1:0] rnd_data_i,
  output logic                 rnd_ready_o,
  output logic                 fu_valid_o,
  output logic                 fu_advance_o,
  output logic [3:0]           fu_op_o,
  output logic [1:0]           fu_bs_o,
  output logic [RND_WIDTH-1:0] fu_randombits_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(SBOX_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       op_q, op_next;
  logic [1:0]       bs_q, bs_next;
  logic             op_onehot;

  assign op_onehot = (op_i != 4'b0000) && ((op_i & (op_i - 4'd1)) == 4'b0000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      bs_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
      bs_q  <= bs_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    op_next         = op_q;
    bs_next         = bs_q;
    req_ready_o     = 1'b0;
    rnd_ready_o     = 1'b0;
    fu_valid_o      = 1'b0;
    fu_advance_o    = 1'b0;
    fu_randombits_o = '0;
    result_valid_o  = 1'b0;

    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        // An illegal op skips the sbox entirely and returns an all-zero op result
        if (req_valid_i && !kill_i) begin
          op_next    = op_onehot ? op_i : 4'b0000;
          bs_next    = bs_i;
          cnt_next   = '0;
          state_next = op_onehot ? RUN : DONE;
        end
      end
      RUN: begin
        fu_valid_o   = 1'b1;
        rnd_ready_o  = !kill_i;
        fu_advance_o = rnd_valid_i && !kill_i;
        if (fu_advance_o) begin
          fu_randombits_o = rnd_data_i;
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        fu_valid_o     = 1'b1;
        result_valid_o = !kill_i;
        if (result_ready_i && !kill_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Kill wins over everything; stale sbox shares get overwritten by the next full run
    if (kill_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  assign busy_o  = (state != IDLE);
  assign fu_op_o = (state == IDLE) ? 4'b0000 : op_q;
  assign fu_bs_o = (state == IDLE) ? 2'b00 : bs_q;

endmodule

// File: tb/tb_cv32e40x_aes_protected_ctrl.sv
// Directed bench for cv32e40x_aes_protected_ctrl; RNG words and result descriptors
// are queued when driven and matched when the DUT advances or hands back a result.
module tb_cv32e40x_aes_protected_ctrl;

  localparam int SBOX_LATENCY = 3;
  localparam int RND_WIDTH    = 36;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic [3:0]           op = 4'b0000;
  logic [1:0]           bs = 2'b00;
  logic                 kill = 1'b0;
  logic                 rnd_valid = 1'b0;
  logic [RND_WIDTH-1:0] rnd_data = '0;
  logic                 result_ready = 1'b0;

  logic                 req_ready_o;
  logic                 rnd_ready_o;
  logic                 fu_valid_o;
  logic                 fu_advance_o;
  logic [3:0]           fu_op_o;
  logic [1:0]           fu_bs_o;
  logic [RND_WIDTH-1:0] fu_randombits_o;
  logic                 result_valid_o;
  logic                 busy_o;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  logic [RND_WIDTH-1:0] rnd_q[$];
  logic [5:0]           res_q[$];
  logic [RND_WIDTH-1:0] exp_rnd;
  logic [5:0]           exp_res;

  cv32e40x_aes_protected_ctrl #(
    .SBOX_LATENCY(SBOX_LATENCY),
    .RND_WIDTH   (RND_WIDTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .op_i           (op),
    .bs_i           (bs),
    .kill_i         (kill),
    .rnd_valid_i    (rnd_valid),
    .rnd_data_i     (rnd_data),
    .rnd_ready_o    (rnd_ready_o),
    .fu_valid_o     (fu_valid_o),
    .fu_advance_o   (fu_advance_o),
    .fu_op_o        (fu_op_o),
    .fu_bs_o        (fu_bs_o),
    .fu_randombits_o(fu_randombits_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [3:0] o, input logic [1:0] b,
                               input logic k, input logic rv, input logic rr);
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    req_valid    = rq;
    op           = o;
    bs           = b;
    kill         = k;
    rnd_valid    = rv;
    rnd_data     = r64[RND_WIDTH-1:0];
    result_ready = rr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every sbox advance must consume exactly the next queued RNG word
  always @(negedge clk) begin
    if (reset_n) begin
      if (rnd_valid && rnd_ready_o) hs_count++;
      if (fu_advance_o) begin
        if (rnd_q.size() == 0) begin
          checkOutput("unexpected_advance", 64'(fu_advance_o), 64'd0);
        end else begin
          exp_rnd = rnd_q.pop_front();
          checkOutput("fu_randombits", 64'(fu_randombits_o), 64'(exp_rnd));
        end
      end else begin
        checkOutput("randombits_zero", 64'(fu_randombits_o), 64'd0);
      end
      if (result_valid_o && result_ready) begin
        if (res_q.size() == 0) begin
          checkOutput("unexpected_result", 64'(result_valid_o), 64'd0);
        end else begin
          exp_res = res_q.pop_front();
          checkOutput("result_op", 64'(fu_op_o), 64'(exp_res[5:2]));
          checkOutput("result_bs", 64'(fu_bs_o), 64'(exp_res[1:0]));
        end
      end
    end
  end

  // One complete operation; cycle 0 is the request cycle, result expected in cycle exp_lat
  task automatic doOp(input string name, input logic [3:0] o, input logic [1:0] b, input logic onehot,
                      input int exp_lat, input int stall_at, input int stall_len, input int hold,
                      input int exp_hs);
    int hs0;
    logic in_run;
    logic rv;
    logic [3:0] exp_op;
    hs0 = hs_count;
    exp_op = onehot ? o : 4'b0000;
    applyStimulus(1'b1, o, b, 1'b0, 1'b1, 1'b0);
    res_q.push_back({exp_op, b});
    @(negedge clk);
    checkOutput({name, "_accept_ready"}, 64'(req_ready_o), 64'd1);
    checkOutput({name, "_accept_busy"}, 64'(busy_o), 64'd0);
    nextCycle();
    for (int cyc = 1; cyc <= exp_lat + hold; cyc++) begin
      in_run = (cyc < exp_lat);
      rv = !(cyc > stall_at && cyc <= stall_at + stall_len);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, rv, (cyc == exp_lat + hold));
      if (in_run && rv) rnd_q.push_back(rnd_data);
      @(negedge clk);
      checkOutput({name, "_result_valid"}, 64'(result_valid_o), 64'(!in_run));
      checkOutput({name, "_busy"}, 64'(busy_o), 64'd1);
      checkOutput({name, "_req_ready"}, 64'(req_ready_o), 64'd0);
      checkOutput({name, "_fu_valid"}, 64'(fu_valid_o), 64'd1);
      checkOutput({name, "_fu_advance"}, 64'(fu_advance_o), 64'(in_run && rv));
      checkOutput({name, "_fu_op"}, 64'(fu_op_o), 64'(exp_op));
      nextCycle();
    end
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({name, "_back_idle"}, 64'(busy_o), 64'd0);
    checkOutput({name, "_ready_again"}, 64'(req_ready_o), 64'd1);
    checkOutput({name, "_handshakes"}, 64'(hs_count - hs0), 64'(exp_hs));
    checkOutput({name, "_rnd_left"}, 64'(rnd_q.size()), 64'd0);
    nextCycle();
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready_o), 64'd1);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_outs", 64'({rnd_ready_o, fu_valid_o, fu_advance_o, fu_op_o, fu_bs_o, result_valid_o}), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    nextCycle();

    doOp("encsm", 4'b1000, 2'd2, 1'b1, SBOX_LATENCY + 1, 100, 0, 0, SBOX_LATENCY);
    doOp("decs_stall", 4'b0001, 2'd1, 1'b1, SBOX_LATENCY + 6, 1, 5, 0, SBOX_LATENCY);
    doOp("encs_hold", 4'b0100, 2'd3, 1'b1, SBOX_LATENCY + 1, 100, 0, 4, SBOX_LATENCY);

    // Kill in RUN after two advances
    applyStimulus(1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    nextCycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
      rnd_q.push_back(rnd_data);
      @(negedge clk);
      checkOutput("kill_pre_advance", 64'(fu_advance_o), 64'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("kill_cycle_outs", 64'({result_valid_o, rnd_ready_o, fu_advance_o}), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("kill_idle_busy", 64'(busy_o), 64'd0);
    checkOutput("kill_no_result", 64'(result_valid_o), 64'd0);
    nextCycle();
    doOp("encs_after_kill", 4'b0100, 2'd0, 1'b1, SBOX_LATENCY + 1, 100, 0, 0, SBOX_LATENCY);

    // Kill together with a request in IDLE
    applyStimulus(1'b1, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("idle_kill_ready", 64'(req_ready_o), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_kill_busy", 64'(busy_o), 64'd0);
    checkOutput("idle_kill_fu_valid", 64'(fu_valid_o), 64'd0);
    nextCycle();

    doOp("non_onehot", 4'b0011, 2'd1, 1'b0, 1, 100, 0, 0, 0);

    // Asynchronous reset with cnt=1
    applyStimulus(1'b1, 4'b1000, 2'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    nextCycle();
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    rnd_q.push_back(rnd_data);
    @(negedge clk);
    nextCycle();
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_ready", 64'(req_ready_o), 64'd1);
    checkOutput("async_reset_busy", 64'(busy_o), 64'd0);
    checkOutput("async_reset_outs", 64'({rnd_ready_o, fu_valid_o, fu_advance_o, fu_op_o, fu_bs_o, result_valid_o}), 64'd0);
    checkOutput("async_reset_rnd", 64'(fu_randombits_o), 64'd0);
    res_q.delete();
    nextCycle();
    reset_n = 1'b1;
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    doOp("decsm_after_reset", 4'b0010, 2'd3, 1'b1, SBOX_LATENCY + 1, 100, 0, 0, SBOX_LATENCY);

    checkOutput("results_left", 64'(res_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
